// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and defaults for the on-chip RAM arbiter.
// Requester ids, read-pipe entry layout and geometry defaults.
package onchip_mem_arb_pkg;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int DEF_DEPTH  = 4093;
    localparam int DEF_ADDR_W = 12;

    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } rd_entry_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; a tie goes to the requester not served last.
// No grant is issued while reset is high.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);
    import onchip_mem_arb_pkg::*;

    logic r_last;
    logic w_gnt_a;
    logic w_gnt_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= ID_B;
        end else if (w_gnt_a) begin
            r_last <= ID_A;
        end else if (w_gnt_b) begin
            r_last <= ID_B;
        end
    end

    always_comb begin
        w_gnt_a = ~reset & i_req_a & (~i_req_b | (r_last == ID_B));
        w_gnt_b = ~reset & i_req_b & ~w_gnt_a;
    end

    assign o_gnt_a = w_gnt_a;
    assign o_gnt_b = w_gnt_b;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters,
// one access per cycle, with tagged read-return and range filtering.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                err_oor,
    input  logic                err_clr
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] LIM = DEPTH[ADDR_W:0];

    logic              w_a_act;
    logic              w_b_act;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wd;
    logic              w_wr;
    logic              w_oor;
    logic              w_cs;
    rd_entry_t         w_push;
    rd_entry_t         w_out;
    logic [DATA_W-1:0] w_rdata;

    rd_entry_t r_pipe [READ_LATENCY];
    logic      r_err;

    assign w_a_act = a_read | a_write;
    assign w_b_act = b_read | b_write;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req_a (w_a_act),
        .i_req_b (w_b_act),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    always_comb begin
        w_addr = a_address;
        w_be   = a_byteenable;
        w_wd   = a_writedata;
        w_wr   = a_write;
        if (w_gnt_b) begin
            w_addr = b_address;
            w_be   = b_byteenable;
            w_wd   = b_writedata;
            w_wr   = b_write;
        end
    end

    assign w_gnt = w_gnt_a | w_gnt_b;
    assign w_oor = ({1'b0, w_addr} >= LIM);
    assign w_cs  = w_gnt & ~w_oor;

    assign mem_chipselect = w_cs;
    assign mem_write      = w_cs & w_wr;
    assign mem_byteenable = w_cs ? w_be : '0;
    assign mem_address    = w_addr;
    assign mem_writedata  = w_wd;
    assign mem_clken      = ~reset;

    assign a_waitrequest = reset | (w_a_act & ~w_gnt_a);
    assign b_waitrequest = reset | (w_b_act & ~w_gnt_b);

    // write wins over a simultaneous read, so only pure reads get tagged
    always_comb begin
        w_push.valid = w_gnt & ~w_wr;
        w_push.id    = w_gnt_b ? ID_B : ID_A;
        w_push.oor   = w_oor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_push;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out = r_pipe[READ_LATENCY-1];

    assign w_rdata = (~reset & w_out.valid & ~w_out.oor) ? mem_readdata : '0;

    assign a_readdata      = w_rdata;
    assign b_readdata      = w_rdata;
    assign a_readdatavalid = ~reset & w_out.valid & (w_out.id == ID_A);
    assign b_readdatavalid = ~reset & w_out.valid & (w_out.id == ID_B);

    // a new out-of-range grant beats a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_gnt & w_oor) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err_oor = r_err;

endmodule
